// File: rtl/text_pkg.sv
// text_pkg: shared state encoding, glyph geometry, character codes and glyph bitmaps for the text renderer
package text_pkg;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 10;
  localparam int MAX_LEN = 16;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SCAN, EMIT, DONE} state_t;
  localparam logic [5:0] CHAR_SPACE   = 6'd0;
  localparam logic [5:0] CHAR_BLOCK   = 6'd1;
  localparam logic [5:0] CHAR_N       = 6'd23;
  localparam logic [5:0] COLOUR_BLOCK = 6'h15;
  localparam logic [5:0] COLOUR_N     = 6'h3C;
  // Letter N: two full-height stems at columns 2 and 6 joined by a three-step diagonal.
  function automatic logic n_lit(input logic [7:0] dx, input logic [7:0] dy);
    return (dy < 8'(GLYPH_H)) &&
           (dx == 8'd2 || dx == 8'd6 ||
            (dx == 8'd3 && dy >= 8'd1 && dy <= 8'd4) ||
            (dx == 8'd4 && dy >= 8'd3 && dy <= 8'd6) ||
            (dx == 8'd5 && dy >= 8'd5 && dy <= 8'd8));
  endfunction
endpackage

// File: rtl/glyph_mux.sv
// glyph_mux: selects the per-character decoder by code; unknown codes (and space) are dark
// Ports: glyph_code/glyph_dx/glyph_dy select a cell; glyph_en/glyph_colour describe that pixel.
module glyph_mux (
  input  logic [5:0] glyph_code,
  input  logic [7:0] glyph_dx,
  input  logic [7:0] glyph_dy,
  output logic       glyph_en,
  output logic [5:0] glyph_colour
);
  import text_pkg::*;
  assign glyph_en = glyph_code == CHAR_BLOCK ? 1'b1 :
                    glyph_code == CHAR_N     ? n_lit(glyph_dx, glyph_dy) :
                    glyph_code == CHAR_SPACE ? 1'b0 : 1'b0;
  assign glyph_colour = glyph_code == CHAR_BLOCK ? COLOUR_BLOCK :
                        glyph_code == CHAR_N     ? COLOUR_N : 6'd0;
endmodule

// File: rtl/text_draw_ctrl.sv
// text_draw_ctrl: walks a string, scans each glyph cell row-major and emits lit pixels as plot requests
// Ports: start/org_x/org_y/len request a draw; str_addr/str_code read the string memory (1-cycle latency);
// glyph_code/glyph_dx/glyph_dy drive a combinational decoder returning glyph_en/glyph_colour;
// plot_x/plot_y/plot_colour/plot_valid handshake with plot_ready; busy and done report progress.
module text_draw_ctrl #(
  parameter int GLYPH_W = text_pkg::GLYPH_W,
  parameter int GLYPH_H = text_pkg::GLYPH_H,
  parameter int LEN_W   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [7:0]       org_x,
  input  logic [7:0]       org_y,
  input  logic [LEN_W-1:0] len,
  output logic [3:0]       str_addr,
  input  logic [5:0]       str_code,
  output logic [5:0]       glyph_code,
  output logic [7:0]       glyph_dx,
  output logic [7:0]       glyph_dy,
  input  logic             glyph_en,
  input  logic [5:0]       glyph_colour,
  output logic [7:0]       plot_x,
  output logic [7:0]       plot_y,
  output logic [5:0]       plot_colour,
  output logic             plot_valid,
  input  logic             plot_ready,
  output logic             busy,
  output logic             done
);
  import text_pkg::*;
  state_t state, state_nx, fin;
  logic [7:0] org_x_q, org_y_q, dx, dy;
  logic [LEN_W-1:0] len_q, char_idx;
  logic [5:0] cur_code;
  logic last_col, last_cell, adv;
  assign last_col  = dx == 8'(GLYPH_W - 1);
  assign last_cell = last_col && dy == 8'(GLYPH_H - 1);
  // A cell is retired either when it is dark in SCAN or when its plot is accepted in EMIT.
  assign adv = (state == SCAN && !glyph_en) || (state == EMIT && plot_ready);
  assign fin = char_idx + LEN_W'(1) == len_q ? DONE : FETCH;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : len == '0 ? DONE : FETCH;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = SCAN;
      SCAN:    state_nx = glyph_en ? EMIT : last_cell ? fin : SCAN;
      EMIT:    state_nx = !plot_ready ? EMIT : last_cell ? fin : SCAN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      org_x_q     <= '0;
      org_y_q     <= '0;
      len_q       <= '0;
      char_idx    <= '0;
      dx          <= '0;
      dy          <= '0;
      cur_code    <= '0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
    end else begin
      if (state == IDLE && start) begin
        org_x_q  <= org_x;
        org_y_q  <= org_y;
        len_q    <= len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : len;
        char_idx <= '0;
        dx       <= '0;
        dy       <= '0;
      end
      if (state == LOAD) cur_code <= str_code;
      // Coordinates wrap modulo 256 by truncation to 8 bits.
      if (state == SCAN && glyph_en) begin
        plot_x      <= org_x_q + 8'(char_idx * GLYPH_W) + dx;
        plot_y      <= org_y_q + dy;
        plot_colour <= glyph_colour;
      end
      if (adv) begin
        dx       <= last_col ? '0 : dx + 8'd1;
        dy       <= !last_col ? dy : last_cell ? '0 : dy + 8'd1;
        char_idx <= last_cell ? char_idx + LEN_W'(1) : char_idx;
      end
    end
  assign str_addr   = char_idx[3:0];
  assign glyph_code = cur_code;
  assign glyph_dx   = dx;
  assign glyph_dy   = dy;
  assign plot_valid = state == EMIT;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
endmodule

// File: tb/tb_text_draw_ctrl.sv
// tb_text_draw_ctrl: scoreboard bench for text_draw_ctrl driven through glyph_mux and a synchronous string memory
module tb_text_draw_ctrl;
  import text_pkg::*;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, plot_ready = 1'b1;
  logic [7:0] org_x = '0, org_y = '0;
  logic [4:0] len = '0;
  logic [3:0] str_addr;
  logic [5:0] str_code, glyph_code, glyph_colour, plot_colour;
  logic [7:0] glyph_dx, glyph_dy, plot_x, plot_y;
  logic glyph_en, plot_valid, busy, done;
  logic [5:0] mem [16];
  logic [7:0] n_rows [10] = '{8'h44, 8'h4C, 8'h4C, 8'h5C, 8'h5C, 8'h74, 8'h74, 8'h64, 8'h64, 8'h44};
  logic [21:0] exp_q [$];
  int errs = 0, checks = 0, cyc = 0, stall_req = 0, stall_cnt = 0;

  text_draw_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .org_x(org_x), .org_y(org_y), .len(len),
    .str_addr(str_addr), .str_code(str_code), .glyph_code(glyph_code), .glyph_dx(glyph_dx),
    .glyph_dy(glyph_dy), .glyph_en(glyph_en), .glyph_colour(glyph_colour), .plot_x(plot_x),
    .plot_y(plot_y), .plot_colour(plot_colour), .plot_valid(plot_valid), .plot_ready(plot_ready),
    .busy(busy), .done(done)
  );
  glyph_mux u_mux (
    .glyph_code(glyph_code), .glyph_dx(glyph_dx), .glyph_dy(glyph_dy),
    .glyph_en(glyph_en), .glyph_colour(glyph_colour)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) str_code <= mem[str_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic lit_f(input logic [5:0] code, input int dx, input int dy);
    return code == CHAR_BLOCK ? 1'b1 : code == CHAR_N ? n_rows[dy][dx] : 1'b0;
  endfunction
  function automatic logic [5:0] col_f(input logic [5:0] code);
    return code == CHAR_BLOCK ? 6'h15 : code == CHAR_N ? 6'h3C : 6'h00;
  endfunction

  always @(negedge clk)
    if (resetn && plot_valid && plot_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL plot_unexpected: got %0h expected none", {plot_x, plot_y, plot_colour});
      end else chk("plot", {10'd0, plot_x, plot_y, plot_colour}, {10'd0, exp_q.pop_front()});
    end

  initial forever begin
    @(negedge clk);
    if (stall_req > 0 && plot_valid && !plot_ready) begin
      if (exp_q.size() > 0) chk("stall_hold", {10'd0, plot_x, plot_y, plot_colour}, {10'd0, exp_q[0]});
      stall_cnt++;
      if (stall_cnt == stall_req) begin
        @(posedge clk);
        #1 plot_ready = 1'b1;
        stall_req = 0;
      end
    end
  end

  task automatic run(input string name, input logic [7:0] ox, input logic [7:0] oy,
                     input logic [4:0] l, input int stalls, input bit hold);
    int n = l > 5'd16 ? 16 : int'(l);
    int lit = 0, s, lat;
    for (int i = 0; i < n; i++)
      for (int y = 0; y < 10; y++)
        for (int x = 0; x < 8; x++)
          if (lit_f(mem[i], x, y)) begin
            exp_q.push_back({8'(int'(ox) + i * 8 + x), 8'(int'(oy) + y), col_f(mem[i])});
            lit++;
          end
    lat = n == 0 ? 1 : n * 82 + lit + stalls + 1;
    if (stalls > 0) begin
      plot_ready = 1'b0;
      stall_cnt = 0;
      stall_req = stalls;
    end
    @(posedge clk);
    #1;
    org_x = ox;
    org_y = oy;
    len = l;
    start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    @(negedge clk);
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    while (!done && cyc - s < 4000) @(negedge clk);
    start = 1'b0;
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL %s_timeout: got no done expected done after %0d cycles", name, lat);
    end else chk({name, "_latency"}, cyc - s, lat);
    chk({name, "_plots_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = CHAR_SPACE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, plot_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_outs", {plot_x, plot_y, plot_colour, str_addr, glyph_code}, 0);
    chk("rst_glyph", {glyph_dx, glyph_dy}, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    run("dark", 8'd0, 8'd0, 5'd1, 0, 1'b1);
    mem[0] = CHAR_BLOCK;
    run("lit", 8'd5, 8'd7, 5'd1, 0, 1'b0);
    mem[0] = CHAR_N;
    mem[1] = CHAR_N;
    run("n2", 8'd10, 8'd20, 5'd2, 0, 1'b0);
    run("stall", 8'd30, 8'd40, 5'd1, 5, 1'b0);
    mem[0] = CHAR_BLOCK;
    run("wrap", 8'd250, 8'd250, 5'd1, 0, 1'b0);
    for (int i = 0; i < 15; i++) mem[i] = CHAR_SPACE;
    mem[15] = CHAR_N;
    run("clamp", 8'd0, 8'd3, 5'd20, 0, 1'b0);
    mem[0] = CHAR_BLOCK;
    plot_ready = 1'b0;
    @(posedge clk);
    #1;
    len = 5'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 10 && !plot_valid; k++) @(negedge clk);
    chk("pre_rst_valid", {31'd0, plot_valid}, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, plot_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_outs", {done, plot_x, plot_y, plot_colour}, 0);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    plot_ready = 1'b1;
    run("len0", 8'd1, 8'd1, 5'd0, 0, 1'b0);
    mem[0] = CHAR_N;
    run("after_rst", 8'd100, 8'd50, 5'd1, 0, 1'b0);
    @(negedge clk);
    chk("end_busy", {31'd0, busy}, 0);
    chk("end_done", {31'd0, done}, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end
endmodule
